// File: rtl/wb_dec_pkg.sv
// Shared sizing helpers and constants for the writeback write decoder.
package wb_dec_pkg;

  localparam int unsigned ZERO_REG = 0;

  function automatic int unsigned nregs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned sel_w(input int unsigned num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/wb_write_decoder_if.sv
// Bus bundle between writeback/issue stages and the write decoder.
// Optional counter port enabled by WB_WRITE_DECODER_CONFLICT_CNT_EN.
interface wb_write_decoder_if
  import wb_dec_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_PORTS = 2
);
  localparam int unsigned NREGS = nregs(ADDR_W);
  localparam int unsigned SEL_W = sel_w(NUM_PORTS);

  logic [NUM_PORTS-1:0]        wb_valid;
  logic [NUM_PORTS*ADDR_W-1:0] wb_reg;
  logic [NUM_PORTS-1:0]        iss_valid;
  logic [NUM_PORTS*ADDR_W-1:0] iss_reg;
  logic                        flush;
  logic [NREGS-1:0]            out_write;
  logic [NREGS*SEL_W-1:0]      out_sel;
  logic                        out_conflict;
  logic [NREGS-1:0]            pending;
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
  logic [15:0]                 conflict_count;
`endif

  modport master (
    output wb_valid, wb_reg, iss_valid, iss_reg, flush,
    input  out_write, out_sel, out_conflict, pending
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    , input conflict_count
`endif
  );

  modport slave (
    input  wb_valid, wb_reg, iss_valid, iss_reg, flush,
    output out_write, out_sel, out_conflict, pending
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    , output conflict_count
`endif
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address-to-one-hot decoder with optional register-0 suppression.
module wb_addr_decode
  import wb_dec_pkg::*;
#(
  parameter int unsigned ADDR_W             = 5,
  parameter int unsigned ZERO_REG_HARDWIRED = 1,
  parameter int unsigned NREGS              = nregs(ADDR_W)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              valid,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (valid) onehot[addr] = 1'b1;
    if (ZERO_REG_HARDWIRED != 0) onehot[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/wb_write_decoder.sv
// Multi-port writeback write-enable decoder with collision priority and pending scoreboard.
// Optional saturating conflict counter enabled by WB_WRITE_DECODER_CONFLICT_CNT_EN.
module wb_write_decoder
  import wb_dec_pkg::*;
#(
  parameter int unsigned ADDR_W             = 5,
  parameter int unsigned NUM_PORTS          = 2,
  parameter int unsigned ZERO_REG_HARDWIRED = 1
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  wb_write_decoder_if.slave  bus
);

  localparam int unsigned NREGS = nregs(ADDR_W);
  localparam int unsigned SEL_W = sel_w(NUM_PORTS);

  logic [NUM_PORTS-1:0][NREGS-1:0] wb_hit;
  logic [NUM_PORTS-1:0][NREGS-1:0] iss_hit;

  logic [NREGS-1:0]       write_d, write_q;
  logic [NREGS*SEL_W-1:0] sel_d, sel_q;
  logic                   conflict_d, conflict_q;
  logic [NREGS-1:0]       wb_any, iss_any;
  logic [NREGS-1:0]       pending_d, pending_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    wb_addr_decode #(
      .ADDR_W             (ADDR_W),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_wb_dec (
      .addr   (bus.wb_reg[p*ADDR_W +: ADDR_W]),
      .valid  (bus.wb_valid[p]),
      .onehot (wb_hit[p])
    );

    wb_addr_decode #(
      .ADDR_W             (ADDR_W),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_iss_dec (
      .addr   (bus.iss_reg[p*ADDR_W +: ADDR_W]),
      .valid  (bus.iss_valid[p]),
      .onehot (iss_hit[p])
    );
  end

  // Ascending port scan: the last (highest) hitting port overwrites sel, and
  // a hit on an already-written register flags a collision.
  always_comb begin
    write_d    = '0;
    sel_d      = '0;
    conflict_d = 1'b0;
    wb_any     = '0;
    iss_any    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wb_hit[p][r]) begin
          if (write_d[r]) conflict_d = 1'b1;
          write_d[r]               = 1'b1;
          sel_d[r*SEL_W +: SEL_W]  = SEL_W'(p);
        end
      end
      wb_any  = wb_any  | wb_hit[p];
      iss_any = iss_any | iss_hit[p];
    end
    pending_d = bus.flush ? '0 : ((pending_q & ~wb_any) | iss_any);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      write_q    <= '0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      write_q    <= write_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.out_write    = write_q;
  assign bus.out_sel      = sel_q;
  assign bus.out_conflict = conflict_q;
  assign bus.pending      = pending_q;

`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
  logic [15:0] count_q;

  // Counts alongside the out_conflict register so both update on the same edge.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)                         count_q <= '0;
    else if (conflict_d && (count_q != '1))    count_q <= count_q + 16'd1;
  end

  assign bus.conflict_count = count_q;
`endif

endmodule

// File: tb/tb_wb_write_decoder.sv
// Directed table-driven bench for wb_write_decoder (2 ports, 32 registers).
module tb_wb_write_decoder;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned NUM_PORTS = 2;

  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  always #5 clock = ~clock;

  wb_write_decoder_if #(.ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) bus ();

  wb_write_decoder #(
    .ADDR_W             (ADDR_W),
    .NUM_PORTS          (NUM_PORTS),
    .ZERO_REG_HARDWIRED (1)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus)
  );

  typedef struct {
    logic [1:0]  wb_valid;
    logic [9:0]  wb_reg;
    logic [1:0]  iss_valid;
    logic [9:0]  iss_reg;
    logic        flush;
    logic [31:0] exp_write;
    logic [31:0] exp_sel;
    logic        exp_conflict;
    logic [31:0] exp_pending;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wv, input logic [9:0] wr,
                       input logic [1:0] iv, input logic [9:0] ir, input logic fl);
    bus.wb_valid  = wv;
    bus.wb_reg    = wr;
    bus.iss_valid = iv;
    bus.iss_reg   = ir;
    bus.flush     = fl;
  endtask

  function automatic vec_t mk(input logic [1:0] wv, input logic [4:0] w1, input logic [4:0] w0,
                              input logic [1:0] iv, input logic [4:0] i1, input logic [4:0] i0,
                              input logic fl, input logic [31:0] ew, input logic [31:0] es,
                              input logic ec, input logic [31:0] ep);
    vec_t v;
    v.wb_valid = wv;  v.wb_reg  = {w1, w0};
    v.iss_valid = iv; v.iss_reg = {i1, i0};
    v.flush = fl;
    v.exp_write = ew; v.exp_sel = es; v.exp_conflict = ec; v.exp_pending = ep;
    return v;
  endfunction

  initial begin
    // wv  w1  w0  iv  i1  i0  fl  write          sel            conf  pending
    vecs.push_back(mk(2'b01, 0,  3, 2'b00, 0,  0, 0, 32'h0000_0008, 32'h0,         0, 32'h0));
    vecs.push_back(mk(2'b11, 17, 5, 2'b00, 0,  0, 0, 32'h0002_0020, 32'h0002_0000, 0, 32'h0));
    vecs.push_back(mk(2'b11, 9,  9, 2'b00, 0,  0, 0, 32'h0000_0200, 32'h0000_0200, 1, 32'h0));
    vecs.push_back(mk(2'b00, 0,  0, 2'b00, 0,  0, 0, 32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(2'b11, 0,  0, 2'b01, 0,  0, 0, 32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(2'b00, 0,  0, 2'b10, 12, 0, 0, 32'h0,         32'h0,         0, 32'h0000_1000));
    vecs.push_back(mk(2'b01, 0, 12, 2'b01, 0, 12, 0, 32'h0000_1000, 32'h0,         0, 32'h0000_1000));
    vecs.push_back(mk(2'b01, 0, 12, 2'b00, 0,  0, 0, 32'h0000_1000, 32'h0,         0, 32'h0));
    vecs.push_back(mk(2'b00, 0,  0, 2'b11, 7,  4, 0, 32'h0,         32'h0,         0, 32'h0000_0090));
    vecs.push_back(mk(2'b01, 0,  4, 2'b01, 0,  8, 1, 32'h0000_0010, 32'h0,         0, 32'h0));
    vecs.push_back(mk(2'b10, 2,  0, 2'b01, 0,  2, 0, 32'h0000_0004, 32'h0000_0004, 0, 32'h0000_0004));
    vecs.push_back(mk(2'b00, 0,  0, 2'b00, 0,  0, 0, 32'h0,         32'h0,         0, 32'h0000_0004));

    // Reset held with both wb ports active across several edges.
    drive(2'b11, {5'd7, 5'd7}, 2'b11, {5'd9, 5'd8}, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_write",    bus.out_write, 32'h0);
    check("rst_sel",      bus.out_sel, 32'h0);
    check("rst_conflict", {31'h0, bus.out_conflict}, 32'h0);
    check("rst_pending",  bus.pending, 32'h0);
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    check("rst_count",    {16'h0, bus.conflict_count}, 32'h0);
`endif

    @(negedge clock);
    ctrl_reset_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].wb_valid, vecs[i].wb_reg, vecs[i].iss_valid, vecs[i].iss_reg, vecs[i].flush);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_write", i),    bus.out_write, vecs[i].exp_write);
      check($sformatf("v%0d_sel", i),      bus.out_sel, vecs[i].exp_sel);
      check($sformatf("v%0d_conflict", i), {31'h0, bus.out_conflict}, {31'h0, vecs[i].exp_conflict});
      check($sformatf("v%0d_pending", i),  bus.pending, vecs[i].exp_pending);
      @(negedge clock);
    end
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    check("count_after_table", {16'h0, bus.conflict_count}, 32'h1);
`endif

    // Mid-operation asynchronous reset after a collision and an issue.
    drive(2'b11, {5'd6, 5'd6}, 2'b01, {5'd0, 5'd20}, 1'b0);
    @(posedge clock);
    #1;
    check("mid_conflict", {31'h0, bus.out_conflict}, 32'h1);
    check("mid_sel",      bus.out_sel, 32'h0000_0040);
    check("mid_pending",  bus.pending, 32'h0010_0004);
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    check("mid_count",    {16'h0, bus.conflict_count}, 32'h2);
`endif
    #1 ctrl_reset_n = 1'b0;
    #1;
    check("async_write",    bus.out_write, 32'h0);
    check("async_sel",      bus.out_sel, 32'h0);
    check("async_conflict", {31'h0, bus.out_conflict}, 32'h0);
    check("async_pending",  bus.pending, 32'h0);
`ifdef WB_WRITE_DECODER_CONFLICT_CNT_EN
    check("async_count",    {16'h0, bus.conflict_count}, 32'h0);
`endif

    // Release and confirm nothing survived the reset.
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    drive(2'b00, '0, 2'b00, '0, 1'b0);
    @(posedge clock);
    #1;
    check("post_write",   bus.out_write, 32'h0);
    check("post_pending", bus.pending, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_write_decoder.md
Name: wb_write_decoder

Overview:
- Parametrised successor to the single-port 5-to-32 regfile write decoder, sized for the 2-wide pipeline.
- Decodes NUM_PORTS writeback destination addresses into one registered write-enable vector, plus a per-register port-select field.
- Resolves same-register write collisions and keeps a pending-write scoreboard (set at issue, cleared at writeback) for the hazard unit.
- Sits between the writeback stage and the register file.

Parameters:
ADDR_W, 5, register address width; NREGS = 2**ADDR_W
NUM_PORTS, 2, number of writeback/issue ports (1..4)
ZERO_REG_HARDWIRED, 1, when 1 register 0 is never enabled and never pending

Ports:
clock  input  1  rising-edge clock
ctrl_reset_n  input  1  asynchronous active-low reset
wb_valid  input  NUM_PORTS  per-port writeback valid
wb_reg  input  NUM_PORTS*ADDR_W  per-port destination; port p at [p*ADDR_W +: ADDR_W]
iss_valid  input  NUM_PORTS  per-port issue of an instruction with a destination
iss_reg  input  NUM_PORTS*ADDR_W  per-port issue destination
flush  input  1  pipeline flush; squashes all pending
out_write  output  NREGS  registered one-hot-per-port write enables to regfile
out_sel  output  NREGS*SEL_W  registered winning port index per register; SEL_W = max(1,clog2(NUM_PORTS))
out_conflict  output  1  registered; two or more valid ports targeted one register
pending  output  NREGS  scoreboard: register has an in-flight writer

Behaviour:
- Reset (ctrl_reset_n low, asynchronous): out_write, out_sel, out_conflict, pending all 0. Release takes effect on the next clock edge.
- Decode latency: wb inputs in cycle N appear on out_write, out_sel and out_conflict in cycle N+1. Outputs with no valid wb are 0.
- out_write[r] = OR over p of (wb_valid[p] && wb_reg[p]==r).
  - r==0 excluded when ZERO_REG_HARDWIRED.
- Collision: multiple valid ports on the same r → highest-indexed port (youngest) wins; out_sel[r] = that index.
  - out_conflict = 1 for exactly that one output cycle.
  - A collision on r==0 with ZERO_REG_HARDWIRED does not raise out_conflict.
- out_sel[r] is 0 whenever out_write[r] is 0.
- Scoreboard update, on each edge:
  - pending[r] cleared when any wb_valid port targets r.
  - pending[r] set when any iss_valid port targets r.
  - Set and clear of the same r in one cycle: set wins, because the issue is a newer producer.
- flush: on the next edge pending becomes all-zero and iss in the same cycle is ignored. The wb decode path is unaffected, since writebacks are committed.
- pending[0] is permanently 0 when ZERO_REG_HARDWIRED.
- Mid-operation reset: all state cleared immediately. No partial writes are held over.
- Purely register outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro WB_WRITE_DECODER_CONFLICT_CNT_EN.
- Defined: adds output conflict_count [15:0].
  - Increments by 1 on every cycle in which out_conflict goes high.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package wb_dec_pkg holds:
  - functions nregs(ADDR_W) and sel_w(NUM_PORTS);
  - localparam ZERO_REG = 0.
- One natural sub-module: wb_addr_decode. It is combinational: ADDR_W address plus valid → NREGS one-hot, with register-0 suppression. It is instantiated NUM_PORTS times for wb and NUM_PORTS times for iss. The top owns the priority merge, the output registers and the scoreboard.

Test Plan:
- Reset: hold ctrl_reset_n low while driving wb_valid=2'b11 → all outputs 0. Release, then wb port0→r3 → next cycle out_write=32'h8, out_sel[3]=0, out_conflict=0.
- Dual distinct writes: port0→r5, port1→r17 → next cycle:
  - out_write=32'h0002_0020;
  - out_sel[5]=0, out_sel[17]=1;
  - out_conflict=0.
- Collision: both ports→r9 → next cycle out_write=32'h200, out_sel[9]=1, out_conflict=1 for one cycle only. With the CNT macro defined, conflict_count=1.
- Register zero: both ports→r0 → out_write=0, out_conflict=0. iss port0→r0 → pending stays 0.
- Scoreboard:
  - iss port1→r12 → pending[12]=1 after the edge.
  - A later wb port0→r12 together with iss port0→r12 → pending[12] stays 1.
  - wb port0→r12 alone → pending[12]=0.
- Flush: pending=r4|r7, then flush=1 with iss→r8 and wb port0→r4 → pending=0 and out_write=32'h10 next cycle.
